// File: rtl/conv_window_mem.sv
// conv_window_mem: per-lane image banks with a k x k window scanner.
// Each lane owns a MEM_DEPTH-word bank. A scan walks a k x k window
// anchored at a per-lane base address in row-major order. Each step
// returns one registered word per lane, one cycle after the step.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no scan active; start latches base/k and enters S_RUN (k>=1)
// S_RUN  | scan active; each step reads one window element per lane
module conv_window_mem #(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 4,
  parameter int IMAGE_HEIGHT = 4,
  parameter int NUM_UNITS    = 2,
  parameter int MAX_KERNEL   = 3,
  localparam int MEM_DEPTH   = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int AW          = $clog2(MEM_DEPTH),
  localparam int KW          = $clog2(MAX_KERNEL + 1)
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_en,
  input  logic                                  i_write,
  input  logic [NUM_UNITS-1:0][AW-1:0]          i_write_addr,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  i_data_in,
  input  logic                                  i_start,
  input  logic [NUM_UNITS-1:0][AW-1:0]          i_start_addr,
  input  logic [KW-1:0]                         i_kernel_dim,
  input  logic                                  i_step,
  output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  o_data_out,
  output logic                                  o_valid,
  output logic                                  o_last,
  output logic                                  o_busy,
  output logic                                  o_done
);

  // Address arithmetic width: base + ky*IMAGE_WIDTH + kx never overflows this.
  localparam int CW  = $clog2(IMAGE_WIDTH);
  localparam int AXW = AW + KW + CW;

  localparam logic [KW-1:0]  KMAX_C  = KW'(MAX_KERNEL);
  localparam logic [AXW-1:0] IW_C    = AXW'(IMAGE_WIDTH);
  localparam logic [AXW-1:0] DEPTH_C = AXW'(MEM_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem [NUM_UNITS][MEM_DEPTH];

  logic [NUM_UNITS-1:0][AW-1:0]         r_base;
  logic [KW-1:0]                        r_k;
  logic [KW-1:0]                        r_kx;
  logic [KW-1:0]                        r_ky;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] r_data_out;
  logic                                 r_valid;
  logic                                 r_last;
  logic                                 r_done;

  logic [KW-1:0]                        w_k_new;
  logic                                 w_wrap_x;
  logic                                 w_last_elem;
  logic                                 w_busy;
  logic                                 w_latch;
  logic                                 w_read;
  logic                                 w_finish;
  logic                                 w_zero_start;
  logic [NUM_UNITS-1:0][AW-1:0]         w_rd_addr;

  // Clamp requested kernel side to the largest supported window.
  assign w_k_new = (i_kernel_dim > KMAX_C) ? KMAX_C : i_kernel_dim;

  // Row-major position tests: end of a row, and end of the whole window.
  assign w_wrap_x    = (r_kx == (r_k - KW'(1)));
  assign w_last_elem = w_wrap_x && (r_ky == (r_k - KW'(1)));

  // State register; reset drops any scan in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; start has priority over step and restarts a running scan.
  always_comb begin
    w_state_nxt = r_state;
    if (i_en) begin
      case (r_state)
        S_IDLE: begin
          if (i_start && (w_k_new != '0)) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (i_start) begin
            w_state_nxt = (w_k_new != '0) ? S_RUN : S_IDLE;
          end else if (i_step && w_last_elem) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded controls for the datapath.
  always_comb begin
    w_busy       = (r_state == S_RUN);
    w_latch      = i_en & i_start;
    w_read       = i_en & i_step & ~i_start & (r_state == S_RUN);
    w_finish     = w_read & w_last_elem;
    w_zero_start = w_latch & (w_k_new == '0);
  end

  // Window element address per lane, wrapped into the bank.
  always_comb begin
    w_rd_addr = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      w_rd_addr[u] = AW'((AXW'(r_base[u]) + AXW'(r_ky) * IW_C + AXW'(r_kx)) % DEPTH_C);
    end
  end

  // Scan context: base/k latched on start, kx/ky advance row-major on each step.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_base <= '0;
      r_k    <= '0;
      r_kx   <= '0;
      r_ky   <= '0;
    end else if (w_latch) begin
      r_base <= i_start_addr;
      r_k    <= w_k_new;
      r_kx   <= '0;
      r_ky   <= '0;
    end else if (w_read) begin
      if (w_wrap_x) begin
        r_kx <= '0;
        r_ky <= r_ky + KW'(1);
      end else begin
        r_kx <= r_kx + KW'(1);
      end
    end
  end

  // Banks are not reset; writes are accepted in any state.
  always_ff @(posedge i_clk) begin
    if (i_en && i_write) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (int'(i_write_addr[u]) < MEM_DEPTH) begin
          r_mem[u][i_write_addr[u]] <= i_data_in[u];
        end
      end
    end
  end

  // Registered read port and status pulses; a same-edge write is not visible.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_valid <= w_read;
      r_last  <= w_finish;
      r_done  <= w_finish | w_zero_start;
      if (w_read) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
          r_data_out[u] <= r_mem[u][w_rd_addr[u]];
        end
      end
    end
  end

  assign o_data_out = r_data_out;
  assign o_valid    = r_valid;
  assign o_last     = r_last;
  assign o_done     = r_done;
  assign o_busy     = w_busy;

endmodule

// File: tb/tb_conv_window_mem.sv
// Bench for conv_window_mem: directed scenarios plus random traffic, checked
// against a queue-based window model by an independent monitor.
module tb_conv_window_mem;

  localparam int DW    = 16;
  localparam int IW    = 4;
  localparam int IH    = 4;
  localparam int NU    = 2;
  localparam int MAXK  = 3;
  localparam int DEPTH = IW * IH;
  localparam int AW    = $clog2(DEPTH);
  localparam int KW    = $clog2(MAXK + 1);

  logic                         i_clk;
  logic                         i_reset;
  logic                         i_en;
  logic                         i_write;
  logic [NU-1:0][AW-1:0]        i_write_addr;
  logic [NU-1:0][DW-1:0]        i_data_in;
  logic                         i_start;
  logic [NU-1:0][AW-1:0]        i_start_addr;
  logic [KW-1:0]                i_kernel_dim;
  logic                         i_step;
  logic [NU-1:0][DW-1:0]        o_data_out;
  logic                         o_valid;
  logic                         o_last;
  logic                         o_busy;
  logic                         o_done;

  conv_window_mem #(
    .DATA_WIDTH  (DW),
    .IMAGE_WIDTH (IW),
    .IMAGE_HEIGHT(IH),
    .NUM_UNITS   (NU),
    .MAX_KERNEL  (MAXK)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (i_en),
    .i_write     (i_write),
    .i_write_addr(i_write_addr),
    .i_data_in   (i_data_in),
    .i_start     (i_start),
    .i_start_addr(i_start_addr),
    .i_kernel_dim(i_kernel_dim),
    .i_step      (i_step),
    .o_data_out  (o_data_out),
    .o_valid     (o_valid),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic [NU-1:0][DW-1:0] d;
    logic                  last;
  } beat_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bank contents, remaining window offsets, scan bases.
  int    mem_m [NU][DEPTH];
  int    m_off [$];
  int    m_base[NU];
  bit    m_busy = 1'b0;
  beat_t exp_q [$];
  int    done_q[$];
  bit    exp_busy = 1'b0;
  logic [NU-1:0][DW-1:0] prev_exp = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit en, input bit wr, input bit st, input bit sp, input int kd,
                     input int b0, input int b1, input int wa0, input int wa1,
                     input int wd0, input int wd1);
    int    k;
    int    off;
    int    bs[NU];
    int    wa[NU];
    int    wd[NU];
    beat_t b;
    @(negedge i_clk);
    bs[0] = b0; bs[1] = b1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
    i_en = en; i_write = wr; i_start = st; i_step = sp;
    i_kernel_dim = KW'(kd);
    for (int u = 0; u < NU; u++) begin
      i_start_addr[u] = AW'(bs[u]);
      i_write_addr[u] = AW'(wa[u]);
      i_data_in[u]    = DW'(wd[u]);
    end
    if (en) begin
      if (st) begin
        k = (kd > MAXK) ? MAXK : kd;
        m_off.delete();
        for (int y = 0; y < k; y++)
          for (int x = 0; x < k; x++)
            m_off.push_back(y * IW + x);
        for (int u = 0; u < NU; u++) m_base[u] = bs[u];
        if (k == 0) begin
          done_q.push_back(1);
          m_busy = 1'b0;
        end else begin
          m_busy = 1'b1;
        end
      end else if (sp && m_busy) begin
        off = m_off.pop_front();
        for (int u = 0; u < NU; u++) b.d[u] = DW'(mem_m[u][(m_base[u] + off) % DEPTH]);
        b.last = (m_off.size() == 0);
        exp_q.push_back(b);
        if (b.last) begin
          done_q.push_back(1);
          m_busy = 1'b0;
        end
      end
      if (wr) for (int u = 0; u < NU; u++) mem_m[u][wa[u] % DEPTH] = wd[u] & 16'hFFFF;
    end
    exp_busy = m_busy;
  endtask

  task automatic start_scan(input int b0, input int b1, input int kd);
    cyc(1, 0, 1, 0, kd, b0, b1, 0, 0, 0, 0);
  endtask

  task automatic step1();
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset = 1'b1;
    i_en = 0; i_write = 0; i_start = 0; i_step = 0; i_kernel_dim = '0;
    i_start_addr = '0; i_write_addr = '0; i_data_in = '0;
    m_busy = 1'b0; m_off.delete(); exp_q.delete(); done_q.delete();
    exp_busy = 1'b0; prev_exp = '0;
    #1;
    chk("reset data_out", 64'(o_data_out), 64'd0);
    chk("reset valid", 64'(o_valid), 64'd0);
    chk("reset last", 64'(o_last), 64'd0);
    chk("reset done", 64'(o_done), 64'd0);
    chk("reset busy", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  // Monitor: pops expected beats / done tokens whenever the DUT presents them.
  initial begin
    beat_t b;
    forever begin
      @(posedge i_clk);
      #1;
      chk("busy", 64'(o_busy), 64'(exp_busy));
      chk("valid", 64'(o_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        if (o_valid) begin
          for (int u = 0; u < NU; u++)
            chk($sformatf("data lane%0d", u), 64'(o_data_out[u]), 64'(b.d[u]));
          chk("last", 64'(o_last), 64'(b.last));
          prev_exp = b.d;
        end
      end else if (!o_valid) begin
        chk("hold data_out", 64'(o_data_out), 64'(prev_exp));
        chk("last idle", 64'(o_last), 64'd0);
      end
      chk("done", 64'(o_done), 64'(done_q.size() != 0));
      if (done_q.size() != 0) void'(done_q.pop_front());
    end
  end

  initial begin
    i_reset = 1'b1;
    i_en = 0; i_write = 0; i_start = 0; i_step = 0; i_kernel_dim = '0;
    i_start_addr = '0; i_write_addr = '0; i_data_in = '0;
    repeat (2) @(negedge i_clk);
    do_reset();

    // Fill banks: lane0 = addr+1, lane1 = addr+100
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, 0, 0, 0, 0, 0, i, i, i + 1, i + 100);
    idle(1);

    // Basic 2x2 window
    start_scan(0, 5, 2);
    repeat (4) step1();
    idle(2);

    // Wrap-around window
    start_scan(15, 15, 2);
    repeat (4) step1();
    idle(2);

    // Zero kernel, then ignored steps in IDLE and with en low
    start_scan(0, 0, 0);
    idle(2);
    step1();
    cyc(0, 0, 1, 0, 2, 3, 3, 0, 0, 0, 0);
    idle(1);

    // Full 3x3 window with an en=0 step in the middle and a trailing step
    start_scan(0, 0, 3);
    repeat (4) step1();
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) step1();
    step1();
    idle(2);

    // Reset mid-scan, then a 1x1 scan
    start_scan(0, 0, 2);
    repeat (2) step1();
    do_reset();
    start_scan(0, 0, 1);
    step1();
    idle(2);

    // Abort by restart
    start_scan(0, 0, 2);
    step1();
    start_scan(4, 4, 2);
    repeat (4) step1();
    idle(2);

    // Read-before-write on the same address, then rescan
    start_scan(0, 0, 1);
    cyc(1, 1, 0, 1, 0, 0, 0, 0, 0, 16'hBEEF, 100);
    idle(1);
    start_scan(0, 0, 1);
    step1();
    idle(2);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom % 8) != 0, ($urandom % 4) == 0, ($urandom % 12) == 0,
          ($urandom % 3) != 0, int'($urandom_range(0, MAXK)),
          int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
          int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end
    idle(3);
    chk("drain beats", 64'(exp_q.size()), 64'd0);
    chk("drain done", 64'(done_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_mem.md
CONV_WINDOW_MEM -- requirements
Module: conv_window_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width per unit.
REQ-002 Parameter IMAGE_WIDTH, default 4, image row length in words.
REQ-003 Parameter IMAGE_HEIGHT, default 4, image rows; MEM_DEPTH = IMAGE_WIDTH*IMAGE_HEIGHT, AW = $clog2(MEM_DEPTH).
REQ-004 Parameter NUM_UNITS, default 2, independent lanes, each with its own bank.
REQ-005 Parameter MAX_KERNEL, default 3, largest kernel side; KW = $clog2(MAX_KERNEL+1).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 en  in  1  global enable; when 0, start/step/write are ignored and FSM state holds.
REQ-009 write  in  1  write strobe, all lanes.
REQ-010 write_addr  in  [NUM_UNITS-1:0][AW-1:0]  per-lane write address.
REQ-011 data_in  in  [NUM_UNITS-1:0][DATA_WIDTH-1:0]  per-lane write data.
REQ-012 start  in  1  begin window scan.
REQ-013 start_addr  in  [NUM_UNITS-1:0][AW-1:0]  per-lane window base address.
REQ-014 kernel_dim  in  KW  window side k.
REQ-015 step  in  1  advance one window element.
REQ-016 data_out  out  [NUM_UNITS-1:0][DATA_WIDTH-1:0]  registered read data.
REQ-017 valid  out  1  data_out holds a new element this cycle.
REQ-018 last  out  1  final window element, coincident with valid.
REQ-019 busy  out  1  FSM in RUN.
REQ-020 done  out  1  one-cycle completion pulse.

Function
REQ-021 Each lane SHALL own a MEM_DEPTH x DATA_WIDTH array; contents not reset.
REQ-022 en&write SHALL write data_in[u] to write_addr[u] of lane u on the rising edge, in any FSM state.
REQ-023 FSM states IDLE and RUN; reset state IDLE.
REQ-024 IDLE, en&start: latch start_addr and k = min(kernel_dim, MAX_KERNEL); clear kx, ky; k>=1 -> RUN next cycle.
REQ-025 IDLE, en&start with kernel_dim=0: stay IDLE, done=1 next cycle, no valid.
REQ-026 RUN, en&step: read lane u at (base[u] + ky*IMAGE_WIDTH + kx) mod MEM_DEPTH; data_out/valid next cycle (latency 1).
REQ-027 Index order row-major: kx increments; kx=k-1 wraps to 0 and increments ky.
REQ-028 Step at kx=ky=k-1: next cycle valid=1, last=1, done=1; FSM returns to IDLE that cycle.
REQ-029 RUN, en&start: abort current scan, relatch per REQ-024; aborted scan produces no done.
REQ-030 step in IDLE, or step with en=0, SHALL be ignored.
REQ-031 Same-cycle write and step to same address: data_out returns old data (read-before-write).
REQ-032 data_out SHALL hold its value when valid=0; valid, last, done deassert otherwise.
REQ-033 Address arithmetic at AW+KW+$clog2(IMAGE_WIDTH) bits, then reduced modulo MEM_DEPTH (wrap-around, no error).

Reset
REQ-034 reset=1 SHALL immediately force IDLE, data_out=0, valid=0, last=0, done=0, busy=0, kx=ky=0.
REQ-035 Reset mid-RUN discards the scan; no done emitted; memory contents retained.

Verification
REQ-036 Write addr i: lane0=i+1, lane1=i+100 (i=0..15); start base{0,5}, k=2, 4 steps -> lane0 1,2,5,6; lane1 105,106,109,110; last and done on 4th valid.
REQ-037 Wrap: base{15,15}, k=2 -> lane0 16,1,4,5; lane1 115,100,103,104.
REQ-038 kernel_dim=0 start -> done pulse next cycle, busy and valid never 1; kernel_dim=3 with MAX_KERNEL=3 -> exactly 9 valids.
REQ-039 Step on addr 0 while writing 0xBEEF to addr 0 -> data_out=1; rescan of addr 0 -> 0xBEEF.
REQ-040 Reset after 2 of 4 steps -> outputs 0, busy 0, no done; then start base{0,0}, k=1, one step -> data_out {1,100}, last=1, done=1.
REQ-041 start with base{4,4} after 1 step of a k=2 scan -> no done for aborted scan; next 4 steps return lane0 5,6,9,10.
